// File: rtl/demux_stream_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// demux_dispatch_pkg : FSM state type and mode encodings for the dispatcher
// Revision: 1.0
// ============================================================================
package demux_dispatch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [1:0] MODE_RR  = 2'b00;
    localparam logic [1:0] MODE_CH0 = 2'b01;
    localparam logic [1:0] MODE_CH1 = 2'b10;

endpackage
`default_nettype wire

// File: rtl/dispatch_credit_ctr.sv
`default_nettype none
// ============================================================================
// dispatch_credit_ctr : saturating per-channel credit counter with overflow pulse
// Revision: 1.0
// ============================================================================
module dispatch_credit_ctr
    import demux_dispatch_pkg::*;
#(
    parameter int CREDIT_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            dec,
    input  logic                            inc,
    output logic [$clog2(CREDIT_MAX+1)-1:0] count,
    output logic                            nonzero,
    output logic                            overflow
);

    localparam int CW = $clog2(CREDIT_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(CREDIT_MAX);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // A simultaneous take and return cancel out, so only lone events move the count.
    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - CW'(1);
            end
        end else if (inc && !dec) begin
            if (count_q == C_MAX) begin
                overflow = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= C_MAX;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule
`default_nettype wire

// File: rtl/demux_stream_dispatcher.sv
`default_nettype none
// ============================================================================
// demux_stream_dispatcher : steers whole packets to one of two credit-gated channels
// Revision: 1.0
// ============================================================================
module demux_stream_dispatcher
    import demux_dispatch_pkg::*;
#(
    parameter int DW         = 8,
    parameter int CREDIT_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic [1:0]    out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic [1:0]    out_ready,
    input  logic [1:0]    credit_ret,
    output logic          sel,
    output logic          busy,
    output logic          cred_err
);

    localparam int CW = $clog2(CREDIT_MAX + 1);

    state_t        state_d, state_q;
    logic          sel_d, sel_q;
    logic          rr_ptr_d, rr_ptr_q;
    logic          cred_err_d, cred_err_q;

    logic [1:0]    w_nonzero;
    logic [1:0]    w_overflow;
    logic [1:0]    w_dec;
    logic [CW-1:0] w_credit_0;
    logic [CW-1:0] w_credit_1;
    logic          w_sel_credit;
    logic          w_fire;

    dispatch_credit_ctr #(.CREDIT_MAX(CREDIT_MAX)) u_ctr0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .dec      (w_dec[0]),
        .inc      (credit_ret[0]),
        .count    (w_credit_0),
        .nonzero  (w_nonzero[0]),
        .overflow (w_overflow[0])
    );

    dispatch_credit_ctr #(.CREDIT_MAX(CREDIT_MAX)) u_ctr1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .dec      (w_dec[1]),
        .inc      (credit_ret[1]),
        .count    (w_credit_1),
        .nonzero  (w_nonzero[1]),
        .overflow (w_overflow[1])
    );

    assign w_sel_credit = sel_q ? (w_credit_1 != '0) : (w_credit_0 != '0);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        in_ready  = 1'b0;
        out_valid = 2'b00;
        w_dec     = 2'b00;
        w_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && in_valid) begin
                    case (mode)
                        MODE_CH0: begin
                            if (w_nonzero[0]) begin
                                sel_d   = 1'b0;
                                state_d = XFER;
                            end
                        end
                        MODE_CH1: begin
                            if (w_nonzero[1]) begin
                                sel_d   = 1'b1;
                                state_d = XFER;
                            end
                        end
                        default: begin
                            // Round-robin falls over to the other channel only when the preferred one is dry.
                            if (w_nonzero[rr_ptr_q]) begin
                                sel_d   = rr_ptr_q;
                                state_d = XFER;
                            end else if (w_nonzero[~rr_ptr_q]) begin
                                sel_d   = ~rr_ptr_q;
                                state_d = XFER;
                            end
                        end
                    endcase
                end
            end
            XFER: begin
                in_ready         = out_ready[sel_q] & w_sel_credit;
                out_valid[sel_q] = in_valid & w_sel_credit;
                w_fire           = in_valid & in_ready;
                w_dec[sel_q]     = w_fire;
                if (w_fire && in_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = ~sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
        cred_err_d = cred_err_q | (|w_overflow);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            rr_ptr_q   <= 1'b0;
            cred_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            cred_err_q <= cred_err_d;
        end
    end

    assign out_data = in_data;
    assign out_last = in_last;
    assign sel      = sel_q;
    assign busy     = (state_q == XFER);
    assign cred_err = cred_err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_dispatcher.sv
`default_nettype none
// ============================================================================
// tb_demux_stream_dispatcher : directed scenarios plus random traffic vs a packet-level model
// Revision: 1.0
// ============================================================================
module tb_demux_stream_dispatcher;
    import demux_dispatch_pkg::*;

    localparam int DW   = 8;
    localparam int CMAX = 4;
    localparam int CW   = $clog2(CMAX + 1);

    logic          clk = 1'b0;
    logic          rst_n, en, in_valid, in_last;
    logic [1:0]    mode, out_ready, credit_ret;
    logic [DW-1:0] in_data;
    logic          in_ready, out_last, sel, busy, cred_err;
    logic [1:0]    out_valid;
    logic [DW-1:0] out_data;

    always #5 clk = ~clk;

    demux_stream_dispatcher #(.DW(DW), .CREDIT_MAX(CMAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .credit_ret (credit_ret),
        .sel        (sel),
        .busy       (busy),
        .cred_err   (cred_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Packet-level reference: who owns the link, which channel, credits as plain integers.
    bit m_busy, m_sel, m_rr, m_err;
    int m_cred [2];

    function automatic logic [5:0] exp_vec();
        logic       r;
        logic [1:0] ov;
        r  = 1'b0;
        ov = 2'b00;
        if (m_busy) begin
            r         = out_ready[m_sel] && (m_cred[m_sel] > 0);
            ov[m_sel] = in_valid && (m_cred[m_sel] > 0);
        end
        return {r, ov, m_sel, m_busy, m_err};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {in_ready, out_valid, sel, busy, cred_err};
    endfunction

    task automatic model_step();
        bit fire, fsel, first;
        int c;
        if (!rst_n) begin
            m_busy = 0; m_sel = 0; m_rr = 0; m_err = 0;
            m_cred[0] = CMAX; m_cred[1] = CMAX;
            return;
        end
        fsel = m_sel;
        fire = m_busy && in_valid && out_ready[m_sel] && (m_cred[m_sel] > 0);
        if (!m_busy && en && in_valid) begin
            if (mode == MODE_CH0 || mode == MODE_CH1) begin
                first = (mode == MODE_CH1);
                if (m_cred[first] > 0) begin m_sel = first; m_busy = 1; end
            end else if (m_cred[m_rr] > 0) begin
                m_sel = m_rr; m_busy = 1;
            end else if (m_cred[!m_rr] > 0) begin
                m_sel = !m_rr; m_busy = 1;
            end
        end else if (fire && in_last) begin
            m_busy = 0;
            m_rr   = !fsel;
        end
        for (int i = 0; i < 2; i++) begin
            c = m_cred[i] - ((fire && fsel == i) ? 1 : 0) + (credit_ret[i] ? 1 : 0);
            if (c > CMAX) begin
                c     = CMAX;
                m_err = 1;
            end
            m_cred[i] = c;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 0; mode = MODE_RR; in_valid = 0; in_data = '0; in_last = 0;
        out_ready = 2'b11; credit_ret = 2'b00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    // Pushes an n-beat packet through, following the DUT handshake; ok=0 if it never completes.
    task automatic drive_pkt(input logic [1:0] md, input int n, input logic [7:0] base, output bit ok);
        int  beat = 0;
        int  cycles = 0;
        bit  fired;
        en = 1; mode = md;
        in_valid = 1; in_data = base; in_last = (n == 1);
        while (beat < n && cycles < 50) begin
            #1;
            fired = in_valid && in_ready;
            tick();
            cycles++;
            if (fired) begin
                beat++;
                in_data = base + 8'(beat);
                in_last = (beat == n - 1);
            end
        end
        in_valid = 0; in_last = 0;
        ok = (beat == n);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 6'b0_00_0_0_0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs_vec(), 6'b0);
        end
        n_checks++;
        if (dut.w_credit_0 !== CW'(CMAX) || dut.w_credit_1 !== CW'(CMAX)) begin
            n_fail++; $display("FAIL reset_credits: got %0d/%0d want %0d/%0d", dut.w_credit_0, dut.w_credit_1, CMAX, CMAX);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        apply_reset();
        mode = MODE_RR; en = 1; out_ready = 2'b11;
        for (int p = 0; p < 3; p++) begin
            want = (p == 1) ? 2'b10 : 2'b01;
            in_valid = 1; in_data = 8'h11 + 8'(p * 16); in_last = 0;
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 2'b00) begin
                n_fail++; $display("FAIL rr_idle p%0d: ready=%b ov=%b want 0/00", p, in_ready, out_valid);
            end
            tick();
            #1;
            n_checks++;
            if (out_valid !== want || in_ready !== 1'b1 || sel !== want[1] || out_data !== in_data) begin
                n_fail++; $display("FAIL rr_first_beat p%0d: ov=%b ready=%b sel=%b data=%h want ov=%b ready=1 data=%h",
                                   p, out_valid, in_ready, sel, out_data, want, in_data);
            end
            tick();
            in_data = in_data + 8'h01; in_last = 1;
            #1;
            n_checks++;
            if (out_valid !== want || out_last !== 1'b1) begin
                n_fail++; $display("FAIL rr_last_beat p%0d: ov=%b last=%b want %b/1", p, out_valid, out_last, want);
            end
            tick();
            in_valid = 0; in_last = 0;
        end
        n_checks++;
        if (dut.w_credit_0 !== CW'(0) || dut.w_credit_1 !== CW'(2)) begin
            n_fail++; $display("FAIL rr_credits: got %0d/%0d want 0/2", dut.w_credit_0, dut.w_credit_1);
        end
    endtask

    task automatic test_credit_skip();
        bit ok;
        apply_reset();
        drive_pkt(MODE_CH0, 4, 8'h40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL skip_setup0: got done=%b want 1", ok); end
        drive_pkt(MODE_CH1, 1, 8'h50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL skip_setup1: got done=%b want 1", ok); end
        n_checks++;
        if (dut.w_credit_0 !== CW'(0) || dut.w_credit_1 !== CW'(3)) begin
            n_fail++; $display("FAIL skip_credits: got %0d/%0d want 0/3", dut.w_credit_0, dut.w_credit_1);
        end
        mode = MODE_RR; en = 1; in_valid = 1; in_data = 8'h60; in_last = 0;
        tick();
        #1;
        n_checks++;
        if (sel !== 1'b1 || out_valid !== 2'b10) begin
            n_fail++; $display("FAIL skip_to_ch1: sel=%b ov=%b want 1/10", sel, out_valid);
        end
        drive_pkt(MODE_RR, 3, 8'h60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL skip_pkt: got done=%b want 1", ok); end
        in_valid = 1; in_data = 8'h70;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL starve_hold c%0d: busy=%b ready=%b want 0/0", k, busy, in_ready);
            end
            tick();
        end
        credit_ret = 2'b01;
        tick();
        credit_ret = 2'b00;
        #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL starve_ret_cycle: busy=%b ready=%b want 0/0", busy, in_ready);
        end
        tick();
        #1;
        n_checks++;
        if (busy !== 1'b1 || sel !== 1'b0 || out_valid !== 2'b01) begin
            n_fail++; $display("FAIL starve_pick: busy=%b sel=%b ov=%b want 1/0/01", busy, sel, out_valid);
        end
        in_last = 1;
        tick();
        in_valid = 0; in_last = 0;
        #1;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL skip_end: got %b want %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_forced_backpressure();
        apply_reset();
        mode = MODE_CH1; en = 1; out_ready = 2'b11;
        in_valid = 1; in_data = 8'hA0; in_last = 0;
        tick();
        #1;
        n_checks++;
        if (out_valid !== 2'b10 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first: ov=%b ready=%b want 10/1", out_valid, in_ready);
        end
        tick();
        in_data = 8'hA1; out_ready = 2'b01;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 2'b10 || out_data !== 8'hA1) begin
                n_fail++; $display("FAIL bp_stall c%0d: ready=%b ov=%b data=%h want 0/10/a1", k, in_ready, out_valid, out_data);
            end
            tick();
        end
        out_ready = 2'b11;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_data !== 8'hA1) begin
            n_fail++; $display("FAIL bp_resume: ready=%b data=%h want 1/a1", in_ready, out_data);
        end
        tick();
        in_data = 8'hA2; in_last = 1;
        tick();
        in_valid = 0; in_last = 0;
        #1;
        n_checks++;
        if (dut.w_credit_1 !== CW'(1) || dut.w_credit_0 !== CW'(4) || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_credits: got %0d/%0d busy=%b want 4/1 busy=0", dut.w_credit_0, dut.w_credit_1, busy);
        end
    endtask

    task automatic test_simul_dec_ret();
        bit ok;
        apply_reset();
        drive_pkt(MODE_CH0, 1, 8'hC0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_setup: got done=%b want 1", ok); end
        mode = MODE_CH0; en = 1; in_valid = 1; in_data = 8'hC1; in_last = 1;
        tick();
        credit_ret = 2'b01;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b want 1", in_ready); end
        tick();
        credit_ret = 2'b00; in_valid = 0; in_last = 0;
        #1;
        n_checks++;
        if (dut.w_credit_0 !== CW'(3) || cred_err !== 1'b0) begin
            n_fail++; $display("FAIL simul_credit: got %0d err=%b want 3 err=0", dut.w_credit_0, cred_err);
        end
        credit_ret = 2'b01;
        tick();
        #1;
        n_checks++;
        if (dut.w_credit_0 !== CW'(4) || cred_err !== 1'b0) begin
            n_fail++; $display("FAIL ret_to_max: got %0d err=%b want 4 err=0", dut.w_credit_0, cred_err);
        end
        tick();
        credit_ret = 2'b00;
        for (int k = 0; k < 3; k++) tick();
        #1;
        n_checks++;
        if (cred_err !== 1'b1 || dut.w_credit_0 !== CW'(4)) begin
            n_fail++; $display("FAIL cred_err_sticky: err=%b credit=%0d want 1/4", cred_err, dut.w_credit_0);
        end
    endtask

    task automatic test_en_drop();
        apply_reset();
        mode = MODE_RR; en = 1; in_valid = 1; in_data = 8'hD0; in_last = 0;
        tick();
        tick();
        en = 0;
        for (int b = 1; b < 4; b++) begin
            in_data = 8'hD0 + 8'(b); in_last = (b == 3);
            #1;
            n_checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 2'b01) begin
                n_fail++; $display("FAIL en_drop_beat%0d: ready=%b busy=%b ov=%b want 1/1/01", b, in_ready, busy, out_valid);
            end
            tick();
        end
        in_last = 0; in_data = 8'hE0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL en_drop_nopick c%0d: busy=%b ready=%b want 0/0", k, busy, in_ready);
            end
            tick();
        end
        in_valid = 0;
        n_checks++;
        if (dut.w_credit_0 !== CW'(0)) begin
            n_fail++; $display("FAIL en_drop_credit: got %0d want 0", dut.w_credit_0);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        apply_reset();
        drive_pkt(MODE_RR, 1, 8'hF0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mrst_setup: got done=%b want 1", ok); end
        mode = MODE_RR; en = 1; in_valid = 1; in_data = 8'hF1; in_last = 0;
        tick();
        tick();
        in_data = 8'hF2;
        tick();
        #1;
        n_checks++;
        if (sel !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mrst_pre: sel=%b busy=%b want 1/1", sel, busy);
        end
        in_data = 8'hF3; rst_n = 0;
        tick();
        #1;
        n_checks++;
        if (obs_vec() !== 6'b0_00_0_0_0 || dut.w_credit_0 !== CW'(4) || dut.w_credit_1 !== CW'(4)) begin
            n_fail++; $display("FAIL mrst_after: got %b credits %0d/%0d want 000000 credits 4/4",
                               obs_vec(), dut.w_credit_0, dut.w_credit_1);
        end
        rst_n = 1; in_valid = 0;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            en         = ($urandom_range(0, 3) != 0);
            mode       = 2'($urandom);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 8'($urandom);
            in_last    = ($urandom_range(0, 2) == 0);
            out_ready  = 2'($urandom);
            credit_ret = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec() || out_data !== in_data || out_last !== in_last) begin
                n_fail++; $display("FAIL rand_outputs c%0d: got %b want %b", cyc, obs_vec(), exp_vec());
            end
            n_checks++;
            if (dut.w_credit_0 !== CW'(m_cred[0]) || dut.w_credit_1 !== CW'(m_cred[1])) begin
                n_fail++; $display("FAIL rand_credits c%0d: got %0d/%0d want %0d/%0d",
                                   cyc, dut.w_credit_0, dut.w_credit_1, m_cred[0], m_cred[1]);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_credit_skip();
        test_forced_backpressure();
        test_simul_dec_ret();
        test_en_drop();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
